boot_loader_ctrl: RTL and testbench

Sequences program download into the instruction memory. It receives a byte stream from the UART receiver, checks a sync byte and a word-count header, and assembles big-endian 32-bit words. It drives the instruction memory's loader_enable, loader_ready and loader_data ports and holds the CPU stalled until the image is complete. It sits between the UART RX block and the instruction memory, and gates the core's run signal.

---
 rtl/core_pkg.sv | 15 +
 rtl/byte_assembler.sv | 33 +++
 rtl/boot_loader_ctrl.sv | 143 ++++++++++++++
 tb/tb_boot_loader_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types for the boot loader: FSM state encoding and the default sync marker.
package core_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } loader_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hAA;

endpackage

// File: rtl/byte_assembler.sv
// Big-endian byte-to-word assembler shared by the length header and the data words.
module byte_assembler (
  input  logic        CLK,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [23:0] held;
  logic [1:0]  pos;

  // The incoming byte completes the 32-bit shift word, so a finished word is
  // usable in the same cycle its last byte is strobed.
  assign word      = {held, byte_in};
  assign word_done = shift && !clear && (pos == 2'd3);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      held <= '0;
      pos  <= '0;
    end else if (clear) begin
      held <= '0;
      pos  <= '0;
    end else if (shift) begin
      held <= word[23:0];
      pos  <= pos + 2'd1;
    end
  end

endmodule

// File: rtl/boot_loader_ctrl.sv
// Downloads a sync + length + big-endian word image from the UART into instruction
// memory, then releases the CPU. status mirrors the FSM state.
module boot_loader_ctrl
  import core_pkg::*;
#(
  parameter int         INST_MEM_WIDTH = 2,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic [31:0]               loader_data,
  output logic                      loader_ready,
  output logic                      loader_enable,
  output logic                      cpu_run,
  output logic                      load_error,
  output logic [INST_MEM_WIDTH:0]   words_loaded,
  output logic [2:0]                status
);

  localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int              WW       = INST_MEM_WIDTH + 1;
  localparam logic [32:0]     CAPACITY = 33'(1) << INST_MEM_WIDTH;
  localparam logic [TW-1:0]   T_LAST   = TW'(TIMEOUT_CYCLES - 1);

  loader_state_t state;
  logic [TW-1:0] tcnt;
  logic [31:0]   count;
  logic          collecting;
  logic          is_sync;
  logic [31:0]   asm_word;
  logic          asm_done;

  assign collecting = (state == LEN) || (state == DATA);
  assign is_sync    = rx_valid && (rx_data == SYNC_BYTE);
  assign status     = state;

  // Held clear outside LEN/DATA, so every entry into collection starts at byte 0
  // and a partial word is dropped on error.
  byte_assembler u_asm (
    .CLK       (CLK),
    .reset     (reset),
    .clear     (!collecting),
    .shift     (rx_valid && collecting),
    .byte_in   (rx_data),
    .word      (asm_word),
    .word_done (asm_done)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      tcnt          <= '0;
      count         <= '0;
      loader_data   <= '0;
      loader_ready  <= 1'b0;
      loader_enable <= 1'b0;
      cpu_run       <= 1'b0;
      load_error    <= 1'b0;
      words_loaded  <= '0;
    end else begin
      loader_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (is_sync) begin
            state         <= LEN;
            loader_enable <= 1'b1;
            tcnt          <= '0;
          end
        end
        LEN: begin
          if (rx_valid) begin
            tcnt <= '0;
            if (asm_done) begin
              if ({1'b0, asm_word} > CAPACITY) begin
                state         <= ERR;
                loader_enable <= 1'b0;
                load_error    <= 1'b1;
              end else if (asm_word == 32'd0) begin
                state         <= DONE;
                loader_enable <= 1'b0;
                cpu_run       <= 1'b1;
              end else begin
                count <= asm_word;
                state <= DATA;
              end
            end
          end else if (tcnt == T_LAST) begin
            state         <= ERR;
            loader_enable <= 1'b0;
            load_error    <= 1'b1;
            tcnt          <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        DATA: begin
          // Checked on the registered count, so the final loader_ready pulse is
          // still seen in DATA and FLUSH follows one cycle later.
          if (32'(words_loaded) == count) begin
            state <= FLUSH;
            tcnt  <= '0;
          end else if (rx_valid) begin
            tcnt <= '0;
            if (asm_done) begin
              loader_ready <= 1'b1;
              loader_data  <= asm_word;
              words_loaded <= words_loaded + WW'(1);
            end
          end else if (tcnt == T_LAST) begin
            state         <= ERR;
            loader_enable <= 1'b0;
            load_error    <= 1'b1;
            tcnt          <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        FLUSH: begin
          state         <= DONE;
          loader_enable <= 1'b0;
          cpu_run       <= 1'b1;
        end
        DONE: begin
          state <= DONE;
        end
        ERR: begin
          if (is_sync) begin
            state         <= LEN;
            load_error    <= 1'b0;
            words_loaded  <= '0;
            loader_enable <= 1'b1;
            tcnt          <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed bench for boot_loader_ctrl with a 4-word memory and a 100-cycle byte timeout.
module tb_boot_loader_ctrl;

  localparam int W  = 2;
  localparam int TO = 100;

  logic          CLK = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [31:0]   loader_data;
  logic          loader_ready;
  logic          loader_enable;
  logic          cpu_run;
  logic          load_error;
  logic [W:0]    words_loaded;
  logic [2:0]    status;

  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;

  boot_loader_ctrl #(.INST_MEM_WIDTH(W), .TIMEOUT_CYCLES(TO), .SYNC_BYTE(8'hAA)) dut (
    .CLK           (CLK),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .loader_data   (loader_data),
    .loader_ready  (loader_ready),
    .loader_enable (loader_enable),
    .cpu_run       (cpu_run),
    .load_error    (load_error),
    .words_loaded  (words_loaded),
    .status        (status)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish want finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  // scoreboard: every loader_ready pulse must match the next expected word and occur in DATA
  always @(negedge CLK) begin
    if (reset === 1'b1 && loader_ready === 1'b1) begin
      pulse_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ready got data %h want no pulse", loader_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (loader_data !== exp_w) begin
          n_err++;
          $display("FAIL ready_data got %h want %h", loader_data, exp_w);
        end
      end
      n_cmp++;
      if (status !== 3'd2) begin
        n_err++;
        $display("FAIL ready_state got %0d want 2", status);
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*(3-k) +: 8]);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    exp_q.delete();
    pulse_cnt = 0;
    idle(1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    n_cmp++; if (status !== 3'd0) begin n_err++; $display("FAIL reset_status got %0d want 0", status); end
    n_cmp++; if (loader_enable !== 1'b0) begin n_err++; $display("FAIL reset_enable got %b want 0", loader_enable); end
    n_cmp++; if (loader_data !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", loader_data); end
    n_cmp++; if ({loader_ready, cpu_run, load_error} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {loader_ready, cpu_run, load_error}); end
    n_cmp++; if (words_loaded !== 3'd0) begin n_err++; $display("FAIL reset_words got %0d want 0", words_loaded); end
    @(negedge CLK);
    do_reset();
    n_cmp++; if (status !== 3'd0) begin n_err++; $display("FAIL post_reset_status got %0d want 0", status); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] img [0:12];
    img = '{8'hAA, 8'h00, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    do_reset();
    exp_q.push_back(32'h12345678);
    exp_q.push_back(32'h9ABCDEF0);
    send_byte(img[0]);
    n_cmp++; if ({status, loader_enable} !== {3'd1, 1'b1}) begin n_err++; $display("FAIL b2b_len_entry got %0d/%b want 1/1", status, loader_enable); end
    for (int i = 1; i < 13; i++) send_byte(img[i]);
    n_cmp++; if (loader_ready !== 1'b1) begin n_err++; $display("FAIL b2b_last_ready got %b want 1", loader_ready); end
    n_cmp++; if (words_loaded !== 3'd2) begin n_err++; $display("FAIL b2b_words got %0d want 2", words_loaded); end
    idle(1);
    n_cmp++; if ({status, loader_enable, loader_ready} !== {3'd3, 1'b1, 1'b0}) begin n_err++; $display("FAIL b2b_flush got %0d/%b/%b want 3/1/0", status, loader_enable, loader_ready); end
    idle(1);
    n_cmp++; if ({status, loader_enable, cpu_run} !== {3'd4, 1'b0, 1'b1}) begin n_err++; $display("FAIL b2b_done got %0d/%b/%b want 4/0/1", status, loader_enable, cpu_run); end
    n_cmp++; if (loader_data !== 32'h9ABCDEF0) begin n_err++; $display("FAIL b2b_data_hold got %h want 9abcdef0", loader_data); end
    n_cmp++; if (pulse_cnt !== 2 || exp_q.size() != 0) begin n_err++; $display("FAIL b2b_pulses got %0d want 2", pulse_cnt); end
    send_byte(8'hAA);
    n_cmp++; if (status !== 3'd4) begin n_err++; $display("FAIL done_sticky got %0d want 4", status); end
  endtask

  task automatic test_noise();
    do_reset();
    send_byte(8'h55); idle(2);
    send_byte(8'h00); idle(2);
    send_byte(8'hFF); idle(2);
    n_cmp++; if ({status, loader_enable} !== {3'd0, 1'b0}) begin n_err++; $display("FAIL noise_idle got %0d/%b want 0/0", status, loader_enable); end
    exp_q.push_back(32'h11223344);
    send_byte(8'hAA); idle(3);
    send_word(32'h00000001);
    send_byte(8'h11); idle(3);
    send_byte(8'h22); idle(3);
    send_byte(8'h33); idle(3);
    send_byte(8'h44); idle(3);
    n_cmp++; if ({cpu_run, words_loaded} !== {1'b1, 3'd1}) begin n_err++; $display("FAIL noise_load got %b/%0d want 1/1", cpu_run, words_loaded); end
    n_cmp++; if (pulse_cnt !== 1) begin n_err++; $display("FAIL noise_pulses got %0d want 1", pulse_cnt); end
  endtask

  task automatic test_oversize();
    do_reset();
    send_byte(8'hAA);
    send_word(32'h00000005);
    n_cmp++; if ({status, load_error, loader_enable, cpu_run} !== {3'd5, 1'b1, 1'b0, 1'b0}) begin n_err++; $display("FAIL over_err got %0d/%b/%b/%b want 5/1/0/0", status, load_error, loader_enable, cpu_run); end
    send_byte(8'hAA);
    n_cmp++; if ({status, load_error, loader_enable} !== {3'd1, 1'b0, 1'b1}) begin n_err++; $display("FAIL over_restart got %0d/%b/%b want 1/0/1", status, load_error, loader_enable); end
    exp_q.push_back(32'h11223344);
    send_word(32'h00000001);
    send_word(32'h11223344);
    idle(2);
    n_cmp++; if ({cpu_run, words_loaded} !== {1'b1, 3'd1}) begin n_err++; $display("FAIL over_reload got %b/%0d want 1/1", cpu_run, words_loaded); end
    n_cmp++; if (pulse_cnt !== 1) begin n_err++; $display("FAIL over_pulses got %0d want 1", pulse_cnt); end
    // high count byte set: low bits alone would look like a 1-word image
    do_reset();
    send_byte(8'hAA);
    send_word(32'h01000001);
    n_cmp++; if ({status, load_error} !== {3'd5, 1'b1}) begin n_err++; $display("FAIL over_wide got %0d/%b want 5/1", status, load_error); end
  endtask

  task automatic test_timeout();
    do_reset();
    send_byte(8'hAA);
    send_word(32'h00000001);
    send_byte(8'h12);
    send_byte(8'h34);
    idle(TO - 1);
    n_cmp++; if (status !== 3'd2) begin n_err++; $display("FAIL to_before got %0d want 2", status); end
    idle(1);
    n_cmp++; if ({status, load_error, loader_enable} !== {3'd5, 1'b1, 1'b0}) begin n_err++; $display("FAIL to_expired got %0d/%b/%b want 5/1/0", status, load_error, loader_enable); end
    n_cmp++; if (pulse_cnt !== 0) begin n_err++; $display("FAIL to_pulses got %0d want 0", pulse_cnt); end
    do_reset();
    send_byte(8'hAA);
    send_word(32'h00000001);
    send_byte(8'h12);
    send_byte(8'h34);
    idle(TO - 1);
    send_byte(8'h56);
    n_cmp++; if ({status, load_error} !== {3'd2, 1'b0}) begin n_err++; $display("FAIL to_rescue got %0d/%b want 2/0", status, load_error); end
    exp_q.push_back(32'h12345678);
    send_byte(8'h78);
    idle(2);
    n_cmp++; if ({cpu_run, pulse_cnt[1:0]} !== {1'b1, 2'd1}) begin n_err++; $display("FAIL to_rescue_load got %b/%0d want 1/1", cpu_run, pulse_cnt); end
  endtask

  task automatic test_zero_count();
    do_reset();
    send_byte(8'hAA);
    send_word(32'h00000000);
    n_cmp++; if ({status, cpu_run, loader_enable} !== {3'd4, 1'b1, 1'b0}) begin n_err++; $display("FAIL zero_done got %0d/%b/%b want 4/1/0", status, cpu_run, loader_enable); end
    n_cmp++; if (words_loaded !== 3'd0 || pulse_cnt !== 0) begin n_err++; $display("FAIL zero_words got %0d/%0d want 0/0", words_loaded, pulse_cnt); end
  endtask

  task automatic test_reset_mid_data();
    logic [31:0] words [0:3];
    words = '{32'h01020304, 32'hA5A55A5A, 32'hDEADBEEF, 32'hFFFFFFFF};
    do_reset();
    send_byte(8'hAA);
    send_word(32'h00000001);
    send_byte(8'h12);
    send_byte(8'h34);
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({status, loader_enable, cpu_run, load_error, loader_ready} !== 7'b0) begin n_err++; $display("FAIL mid_reset got %0d/%b/%b/%b/%b want all 0", status, loader_enable, cpu_run, load_error, loader_ready); end
    @(negedge CLK);
    reset = 1'b1;
    idle(1);
    n_cmp++; if (status !== 3'd0) begin n_err++; $display("FAIL mid_release got %0d want 0", status); end
    send_byte(8'hAA);
    send_word(32'h00000004);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(words[i]);
      send_word(words[i]);
    end
    n_cmp++; if (words_loaded !== 3'd4) begin n_err++; $display("FAIL full_words got %0d want 4", words_loaded); end
    idle(2);
    n_cmp++; if ({cpu_run, loader_enable} !== 2'b10) begin n_err++; $display("FAIL full_done got %b/%b want 1/0", cpu_run, loader_enable); end
    n_cmp++; if (pulse_cnt !== 4 || exp_q.size() != 0) begin n_err++; $display("FAIL full_pulses got %0d want 4", pulse_cnt); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_noise();
    test_oversize();
    test_timeout();
    test_zero_count();
    test_reset_mid_data();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
